// File: rtl/sc_mult_sequencer.sv
// Stochastic-computing multiplier sequencer: two LFSR-driven bitstreams are
// compared against latched operands, multiplied (AND/XNOR) and popcounted over N cycles.
module sc_mult_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic       mode,
  input  logic [1:0] len_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       sn_bit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [30:0] SEED_A = 31'h0000_0001;
  localparam logic [30:0] SEED_B = 31'h0000_0002;

  state_e      state_q, state_d;
  logic [3:0]  op_a_q, op_a_d;
  logic [3:0]  op_b_q, op_b_d;
  logic        mode_q, mode_d;
  logic [1:0]  len_sel_q, len_sel_d;
  logic [7:0]  ones_q, ones_d;
  logic [6:0]  cyc_q, cyc_d;
  logic [30:0] lfsr_a_q, lfsr_a_d;
  logic [30:0] lfsr_b_q, lfsr_b_d;
  logic [7:0]  result_q, result_d;

  logic       bit_a, bit_b, product;
  logic [6:0] last_cyc;

  always_comb begin
    bit_a   = (lfsr_a_q[30:27] < op_a_q);
    bit_b   = (lfsr_b_q[30:27] < op_b_q);
    product = mode_q ? ~(bit_a ^ bit_b) : (bit_a & bit_b);
    case (len_sel_q)
      2'd0:    last_cyc = 7'd15;
      2'd1:    last_cyc = 7'd31;
      2'd2:    last_cyc = 7'd63;
      default: last_cyc = 7'd127;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mode_d    = mode_q;
    len_sel_d = len_sel_q;
    ones_d    = ones_q;
    cyc_d     = cyc_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          op_a_d    = op_a;
          op_b_d    = op_b;
          mode_d    = mode;
          len_sel_d = len_sel;
          ones_d    = 8'd0;
          cyc_d     = 7'd0;
          lfsr_a_d  = SEED_A;
          lfsr_b_d  = SEED_B;
        end
      end
      RUN: begin
        lfsr_a_d = {lfsr_a_q[29:0], lfsr_a_q[30] ^ lfsr_a_q[27]};
        lfsr_b_d = {lfsr_b_q[29:0], lfsr_b_q[30] ^ lfsr_b_q[27]};
        ones_d   = ones_q + {7'd0, product};
        cyc_d    = cyc_q + 7'd1;
        // Abort wins over completion, so result is only written on a clean finish.
        if (abort) begin
          state_d = IDLE;
        end else if (cyc_q == last_cyc) begin
          state_d  = DONE;
          // Loaded on the way into DONE so result is already valid while done is high.
          result_d = ones_q + {7'd0, product};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= 4'd0;
      op_b_q    <= 4'd0;
      mode_q    <= 1'b0;
      len_sel_q <= 2'd0;
      ones_q    <= 8'd0;
      cyc_q     <= 7'd0;
      lfsr_a_q  <= SEED_A;
      lfsr_b_q  <= SEED_B;
      result_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      mode_q    <= mode_d;
      len_sel_q <= len_sel_d;
      ones_q    <= ones_d;
      cyc_q     <= cyc_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign sn_bit = (state_q == RUN) && product;
  assign result = result_q;

endmodule

// File: tb/tb_sc_mult_sequencer.sv
// Bench for sc_mult_sequencer: randomized runs checked against a bitstream-level
// reference model, plus directed reset, abort, busy-start and back-to-back scenarios.
module tb_sc_mult_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] op_a, op_b;
  logic       mode;
  logic [1:0] len_sel;
  logic       busy, done, sn_bit;
  logic [7:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_result;
  bit         exp_sn[0:127];

  sc_mult_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .mode(mode), .len_sel(len_sel),
    .busy(busy), .done(done), .result(result), .sn_bit(sn_bit)
  );

  always #5 clk = ~clk;

  // Reference: walk both generators for N steps, record each product bit and the ones count.
  task automatic model_run(input logic [3:0] a, input logic [3:0] b, input logic m,
                           input logic [1:0] ls, output int ones);
    logic [30:0] la, lb;
    logic [3:0]  ta, tb;
    int n;
    bit ba, bb, p;
    la = 31'h1;
    lb = 31'h2;
    n = 16 << ls;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      ta = la[30:27];
      tb = lb[30:27];
      ba = (ta < a);
      bb = (tb < b);
      p  = m ? (ba == bb) : (ba && bb);
      exp_sn[i] = p;
      ones += int'(p);
      la = {la[29:0], la[30] ^ la[27]};
      lb = {lb[29:0], lb[30] ^ lb[27]};
    end
  endtask

  task automatic apply_start(input logic [3:0] a, input logic [3:0] b, input logic m,
                             input logic [1:0] ls);
    @(negedge clk);
    op_a = a; op_b = b; mode = m; len_sel = ls; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full run; optionally scrambles the operand inputs while it is in flight.
  task automatic run_check(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic m, input logic [1:0] ls, input bit scramble);
    int ones, n, cyc, dn, nb, snerr;
    logic [7:0] exp_r;
    model_run(a, b, m, ls, ones);
    n = 16 << ls;
    exp_q.push_back(8'(ones));
    apply_start(a, b, m, ls);
    cyc = 0; dn = 0; nb = 0; snerr = 0;
    while (busy === 1'b1 && cyc < 400) begin
      if (done === 1'b1) begin
        dn++;
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (result !== exp_r) begin
          n_fail++;
          $display("FAIL %s result: got %0d expected %0d", name, result, exp_r);
        end
        last_result = exp_r;
      end else begin
        if (nb < 128 && sn_bit !== exp_sn[nb]) snerr++;
        nb++;
      end
      cyc++;
      if (scramble) begin
        op_a = 4'($urandom); op_b = 4'($urandom);
        mode = 1'($urandom); len_sel = 2'($urandom);
      end
      @(negedge clk);
    end
    n_checks++;
    if (cyc != n + 1) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, cyc, n + 1);
    end
    n_checks++;
    if (dn != 1 || snerr != 0) begin
      n_fail++;
      $display("FAIL %s stream: done_pulses %0d sn_errors %0d expected 1 and 0", name, dn, snerr);
    end
    n_checks++;
    if (result !== last_result || sn_bit !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_hold: result %0d sn %b done %b expected %0d 0 0",
               name, result, sn_bit, done, last_result);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    op_a = '0; op_b = '0; mode = 1'b0; len_sel = '0;
    last_result = 8'd0;
    #2;
    n_checks++;
    if ({busy, done, sn_bit, result} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy %b done %b sn %b result %0d expected all 0",
               busy, done, sn_bit, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy %b expected 0", busy);
    end
  endtask

  task automatic test_unipolar_zero;
    run_check("unipolar_zero", 4'd0, 4'd15, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_bipolar_zero;
    int ones;
    model_run(4'd0, 4'd0, 1'b1, 2'd3, ones);
    n_checks++;
    if (ones != 128) begin
      n_fail++;
      $display("FAIL bipolar_model: got %0d expected 128", ones);
    end
    run_check("bipolar_zero", 4'd0, 4'd0, 1'b1, 2'd3, 1'b0);
  endtask

  task automatic abort_at(input string name, input logic [1:0] ls, input int k);
    int dn;
    dn = 0;
    apply_start(4'($urandom), 4'($urandom), 1'($urandom), ls);
    for (int i = 1; i < k; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dn != 0 || result !== last_result) begin
      n_fail++;
      $display("FAIL %s: busy %b done %b early_done %0d result %0d expected 0 0 0 %0d",
               name, busy, done, dn, result, last_result);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || result !== last_result) begin
      n_fail++;
      $display("FAIL %s_after: busy %b result %0d expected 0 %0d", name, busy, result, last_result);
    end
  endtask

  task automatic test_abort;
    run_check("pre_abort", 4'd11, 4'd7, 1'b0, 2'd1, 1'b0);
    abort_at("abort_cycle10", 2'd2, 10);
    abort_at("abort_last", 2'd0, 16);
  endtask

  task automatic test_busy_start;
    int ones, bc, dn;
    logic [7:0] exp_r;
    model_run(4'd6, 4'd13, 1'b0, 2'd0, ones);
    exp_r = 8'(ones);
    apply_start(4'd6, 4'd13, 1'b0, 2'd0);
    bc = 0; dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1) dn++;
      start = (i == 5) || (done === 1'b1);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (bc != 17 || dn != 1 || result !== exp_r) begin
      n_fail++;
      $display("FAIL busy_start: busy_cycles %0d dones %0d result %0d expected 17 1 %0d",
               bc, dn, result, exp_r);
    end
    last_result = exp_r;
  endtask

  task automatic test_back_to_back;
    int ones, errs, dn, wait_c;
    bit exp_busy;
    logic [7:0] exp_r;
    model_run(4'd3, 4'd12, 1'b1, 2'd0, ones);
    exp_r = 8'(ones);
    @(negedge clk);
    op_a = 4'd3; op_b = 4'd12; mode = 1'b1; len_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    errs = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      exp_busy = ((i % 18) != 17);
      if (busy !== exp_busy) errs++;
      if (done === 1'b1) begin
        dn++;
        if (result !== exp_r) errs++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (errs != 0 || dn != 2) begin
      n_fail++;
      $display("FAIL back_to_back: errors %0d dones %0d expected 0 2", errs, dn);
    end
    wait_c = 0;
    while (busy === 1'b1 && wait_c < 200) begin
      wait_c++;
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || result !== exp_r) begin
      n_fail++;
      $display("FAIL back_to_back_drain: busy %b result %0d expected 0 %0d", busy, result, exp_r);
    end
    last_result = exp_r;
  endtask

  task automatic test_golden;
    for (int m = 0; m < 2; m++)
      for (int ls = 0; ls < 4; ls++)
        for (int r = 0; r < 2; r++)
          run_check($sformatf("golden_m%0d_l%0d_r%0d", m, ls, r), 4'd9, 4'd5, 1'(m), 2'(ls), 1'b0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++)
      run_check($sformatf("random_%0d", t), 4'($urandom), 4'($urandom), 1'($urandom),
                2'($urandom_range(0, 3)), 1'b1);
  endtask

  task automatic test_reset_midrun;
    apply_start(4'd10, 4'd10, 1'b0, 2'd3);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sn_bit, result} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: busy %b done %b sn %b result %0d expected all 0",
               busy, done, sn_bit, result);
    end
    last_result = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_%0d: busy %b done %b expected 0 0", i, busy, done);
      end
    end
    run_check("after_reset", 4'd9, 4'd5, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_unipolar_zero;
    test_bipolar_zero;
    test_abort;
    test_busy_start;
    test_back_to_back;
    test_golden;
    test_random;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_mult_sequencer.md
SC_MULT_SEQUENCER -- requirements
Module: sc_mult_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new multiply; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: cancel the run in progress; sampled only in RUN.
REQ-005 SHALL have port op_a, input, 4 bits: operand A probability, value/16.
REQ-006 SHALL have port op_b, input, 4 bits: operand B probability, value/16.
REQ-007 SHALL have port mode, input, 1 bit: 0 = unipolar (AND), 1 = bipolar (XNOR); latched at start.
REQ-008 SHALL have port len_sel, input, 2 bits: window length N = 16, 32, 64, 128 for codes 0..3; latched at start.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when result is updated.
REQ-011 SHALL have port result, output, 8 bits: count of 1s in the product stream of the last completed run.
REQ-012 SHALL have port sn_bit, output, 1 bit: current product bit; 0 outside RUN.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL move IDLE->RUN on start=1, capturing op_a, op_b, mode and len_sel into registers, zeroing the ones counter and the cycle counter, and loading lfsr_a=31'h0000_0001 and lfsr_b=31'h0000_0002.
REQ-015 SHALL advance both LFSRs once per RUN cycle, each as a 31-bit Fibonacci LFSR with polynomial x^31+x^28+1 (new bit0 = bit30 XOR bit27, shift left); LFSRs SHALL hold in IDLE and DONE.
REQ-016 SHALL form, combinationally each RUN cycle, bit_a = (lfsr_a[30:27] < op_a_reg) and bit_b = (lfsr_b[30:27] < op_b_reg), unsigned compare.
REQ-017 SHALL form product = bit_a AND bit_b when mode_reg=0, and product = bit_a XNOR bit_b when mode_reg=1; sn_bit SHALL equal product in RUN.
REQ-018 SHALL add product to the 8-bit ones counter every RUN cycle; counter cannot overflow because N <= 128.
REQ-019 SHALL leave RUN for DONE after exactly N RUN cycles, where the cycle counter reaching N-1 is the last RUN cycle.
REQ-020 SHALL, in DONE (exactly one cycle), load result with the final ones count and assert done for that cycle, then return to IDLE.
REQ-021 SHALL hold result stable from one DONE until the next DONE; abort and start SHALL NOT alter it.
REQ-022 SHALL ignore start while busy=1, including start during the DONE cycle.
REQ-023 SHALL, when abort=1 in any RUN cycle including the last, go to IDLE on the next edge with no DONE, no done pulse and result unchanged.
REQ-024 SHALL give abort priority over normal RUN->DONE completion when both occur in the same cycle.
REQ-025 SHALL ignore changes on op_a, op_b, mode and len_sel after start has been accepted.
REQ-026 SHALL accept back-to-back runs, so start held high yields a new RUN on the cycle after each DONE returns to IDLE.

Reset
REQ-027 SHALL, while rst_n=0 and independent of clk, force state=IDLE, busy=0, done=0, sn_bit=0, result=8'h00, both counters=0, lfsr_a=31'h1, lfsr_b=31'h2 and all operand registers=0.
REQ-028 SHALL handle reset asserted mid-RUN by abandoning the run with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-029 Reset mid-RUN: apply rst_n=0 -> all outputs 0 immediately; after release, busy stays 0 until start.
REQ-030 Unipolar zero: op_a=0, op_b=15, mode=0, len_sel=0, start -> busy for 17 cycles, done pulse, result=0.
REQ-031 Bipolar zero-zero: op_a=0, op_b=0, mode=1, len_sel=3 -> sn_bit=1 for all 128 RUN cycles, result=128 (8'h80).
REQ-032 Abort: start with len_sel=2, abort on RUN cycle 10 -> IDLE next cycle, no done, result keeps its previous value.
REQ-033 Busy start: start re-pulsed during RUN and DONE -> ignored; exactly one done per accepted start.
REQ-034 Golden model: op_a=9, op_b=5, both modes, all len_sel values -> result matches a bit-exact reference LFSR model; rerun gives an identical result because the LFSRs are reseeded.
